fx_narrow_pipe: RTL

- Pipelined fixed-point narrowing converter: signed IW-bit input with IF fractional bits to signed OW-bit output with OF fractional bits.
- Drops LSBs with a selectable rounding mode, then removes excess MSBs by saturation or wrap.
- This is the narrowing counterpart of the sign-extending format matchers. It sits at datapath stage boundaries where word width must shrink, e.g. before storage or a downstream multiplier.
- Also provides overflow monitoring: a per-sample flag, a sticky flag and an event counter.

---
 rtl/fx_pkg.sv | 21 ++
 rtl/fx_round_stage.sv | 62 ++++++
 rtl/fx_narrow_pipe.sv | 98 +++++++++
 3 files changed

// File: rtl/fx_pkg.sv
// Shared constants and helpers for the fixed-point format converters.
// Mode encodings and signed range limits are shared by every narrowing block.
package fx_pkg;

  localparam int ROUND_TRUNC   = 0;
  localparam int ROUND_HALF_UP = 1;
  localparam int ROUND_CONV    = 2;

  localparam int SAT_WRAP  = 0;
  localparam int SAT_CLAMP = 1;

  // Largest and smallest two's-complement values representable in w bits.
  function automatic logic signed [63:0] fx_max(input int w);
    return (64'sd1 <<< (w - 1)) - 64'sd1;
  endfunction

  function automatic logic signed [63:0] fx_min(input int w);
    return -(64'sd1 <<< (w - 1));
  endfunction

endpackage

// File: rtl/fx_round_stage.sv
// Drops D_LSB fractional bits with the selected rounding mode and registers the result.
// The output carries one guard bit so a round-up carry out of the MSB is never lost.
module fx_round_stage
  import fx_pkg::*;
#(
  parameter int IW         = 14,
  parameter int D_LSB      = 2,
  parameter int ROUND_MODE = ROUND_HALF_UP
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              en,
  input  logic              i_valid,
  input  logic [IW-1:0]     i_data,
  output logic              o_valid,
  output logic [IW-D_LSB:0] o_data
);

  localparam int RW = IW - D_LSB + 1;

  logic [IW:0]   ext;
  logic [RW-1:0] rnd;

  assign ext = {i_data[IW-1], i_data};

  generate
    if (D_LSB == 0) begin : g_pass
      assign rnd = ext;
    end else begin : g_round
      localparam logic [IW:0] HALF = (IW+1)'(1) << (D_LSB - 1);

      logic        add_half;
      logic [IW:0] sum;
      logic        unused_lsbs;

      // Convergent skips the half-LSB bias only on an exact tie with an even kept LSB.
      always_comb begin
        add_half = 1'b0;
        if (ROUND_MODE == ROUND_HALF_UP) begin
          add_half = 1'b1;
        end else if (ROUND_MODE == ROUND_CONV) begin
          add_half = !((ext[D_LSB-1:0] == HALF[D_LSB-1:0]) && !ext[D_LSB]);
        end
      end

      assign sum         = ext + (add_half ? HALF : '0);
      assign rnd         = sum[IW:D_LSB];
      assign unused_lsbs = ^sum[D_LSB-1:0];
    end
  endgenerate

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      o_valid <= 1'b0;
      o_data  <= '0;
    end else if (en) begin
      o_valid <= i_valid;
      o_data  <= rnd;
    end
  end

endmodule

// File: rtl/fx_narrow_pipe.sv
// Two-stage signed fixed-point narrowing converter: round off LSBs, then saturate or wrap MSBs.
// Valid semantics: a sample is accepted on every enabled edge with i_valid=1; there is no backpressure.
module fx_narrow_pipe
  import fx_pkg::*;
#(
  parameter int IW         = 14,
  parameter int IF         = 6,
  parameter int OW         = 10,
  parameter int OF         = 4,
  parameter int ROUND_MODE = ROUND_HALF_UP,
  parameter int SAT_MODE   = SAT_CLAMP,
  parameter int CNT_W      = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_en,
  input  logic             i_valid,
  input  logic [IW-1:0]    i_data,
  input  logic             i_clr,
  output logic             o_valid,
  output logic [OW-1:0]    o_data,
  output logic             o_ovf,
  output logic             o_ovf_sticky,
  output logic [CNT_W-1:0] o_ovf_cnt
);

  localparam int D_LSB = IF - OF;
  localparam int D_MSB = (IW - IF) - (OW - OF);
  localparam int RW    = IW - D_LSB + 1;

  localparam logic signed [63:0] MAX64 = fx_max(OW);
  localparam logic signed [63:0] MIN64 = fx_min(OW);
  localparam logic [OW-1:0]      O_MAX = MAX64[OW-1:0];
  localparam logic [OW-1:0]      O_MIN = MIN64[OW-1:0];

  generate
    if (D_LSB < 0 || D_MSB < 0 || ROUND_MODE < 0 || ROUND_MODE > 2
        || SAT_MODE < 0 || SAT_MODE > 1) begin : g_bad_params
      $error("fx_narrow_pipe: illegal parameters (formats must narrow, modes in range)");
    end
  endgenerate

  logic          s1_valid;
  logic [RW-1:0] s1_data;
  logic          ovf;
  logic [OW-1:0] nxt_data;

  fx_round_stage #(
    .IW         (IW),
    .D_LSB      (D_LSB),
    .ROUND_MODE (ROUND_MODE)
  ) u_round (
    .clk     (clk),
    .rst_n   (rst_n),
    .en      (i_en),
    .i_valid (i_valid),
    .i_data  (i_data),
    .o_valid (s1_valid),
    .o_data  (s1_data)
  );

  // In range only when every bit from the output sign upward matches.
  assign ovf = !((&s1_data[RW-1:OW-1]) || !(|s1_data[RW-1:OW-1]));

  always_comb begin
    nxt_data = s1_data[OW-1:0];
    if (SAT_MODE == SAT_CLAMP && ovf) begin
      nxt_data = s1_data[RW-1] ? O_MIN : O_MAX;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      o_valid      <= 1'b0;
      o_data       <= '0;
      o_ovf        <= 1'b0;
      o_ovf_sticky <= 1'b0;
      o_ovf_cnt    <= '0;
    end else begin
      if (i_en) begin
        o_valid <= s1_valid;
        o_data  <= nxt_data;
        o_ovf   <= s1_valid && ovf;
      end
      // Clear works even while stalled and beats a same-cycle overflow.
      if (i_clr) begin
        o_ovf_sticky <= 1'b0;
        o_ovf_cnt    <= '0;
      end else if (i_en && s1_valid && ovf) begin
        o_ovf_sticky <= 1'b1;
        if (!(&o_ovf_cnt)) begin
          o_ovf_cnt <= o_ovf_cnt + CNT_W'(1);
        end
      end
    end
  end

endmodule
